// File: rtl/rop_types.sv
// Shared ROP DCR types: active/staging state layout, register indices, reset value.
package rop_types;

  localparam int ROP_FUNC_BITS  = 3;
  localparam int ROP_OP_BITS    = 3;
  localparam int ROP_MODE_BITS  = 3;
  localparam int ROP_BLEND_BITS = 4;
  localparam int ROP_LOGIC_BITS = 4;

  typedef struct packed {
    logic [31:0]               cbuf_addr;
    logic [31:0]               cbuf_pitch;
    logic [31:0]               cbuf_mask;
    logic [31:0]               zbuf_addr;
    logic [31:0]               zbuf_pitch;
    logic [ROP_FUNC_BITS-1:0]  depth_func;
    logic                      depth_writemask;
    logic [ROP_FUNC_BITS-1:0]  stencil_front_func;
    logic [ROP_FUNC_BITS-1:0]  stencil_back_func;
    logic [ROP_OP_BITS-1:0]    stencil_front_zpass;
    logic [ROP_OP_BITS-1:0]    stencil_back_zpass;
    logic [ROP_OP_BITS-1:0]    stencil_front_zfail;
    logic [ROP_OP_BITS-1:0]    stencil_back_zfail;
    logic [ROP_OP_BITS-1:0]    stencil_front_fail;
    logic [ROP_OP_BITS-1:0]    stencil_back_fail;
    logic [7:0]                stencil_front_ref;
    logic [7:0]                stencil_back_ref;
    logic [7:0]                stencil_front_mask;
    logic [7:0]                stencil_back_mask;
    logic [ROP_MODE_BITS-1:0]  blend_mode_rgb;
    logic [ROP_MODE_BITS-1:0]  blend_mode_a;
    logic [ROP_BLEND_BITS-1:0] blend_src_rgb;
    logic [ROP_BLEND_BITS-1:0] blend_src_a;
    logic [ROP_BLEND_BITS-1:0] blend_dst_rgb;
    logic [ROP_BLEND_BITS-1:0] blend_dst_a;
    logic [31:0]               blend_const;
    logic [ROP_LOGIC_BITS-1:0] logic_op;
  } rop_dcrs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DONE
  } commit_state_t;

  localparam logic [4:0] ROP_DCR_CBUF_ADDR     = 5'h00;
  localparam logic [4:0] ROP_DCR_CBUF_PITCH    = 5'h01;
  localparam logic [4:0] ROP_DCR_CBUF_MASK     = 5'h02;
  localparam logic [4:0] ROP_DCR_ZBUF_ADDR     = 5'h03;
  localparam logic [4:0] ROP_DCR_ZBUF_PITCH    = 5'h04;
  localparam logic [4:0] ROP_DCR_DEPTH_FUNC    = 5'h05;
  localparam logic [4:0] ROP_DCR_DEPTH_MASK    = 5'h06;
  localparam logic [4:0] ROP_DCR_STENCIL_FUNC  = 5'h07;
  localparam logic [4:0] ROP_DCR_STENCIL_ZPASS = 5'h08;
  localparam logic [4:0] ROP_DCR_STENCIL_ZFAIL = 5'h09;
  localparam logic [4:0] ROP_DCR_STENCIL_FAIL  = 5'h0A;
  localparam logic [4:0] ROP_DCR_STENCIL_REF   = 5'h0B;
  localparam logic [4:0] ROP_DCR_STENCIL_MASK  = 5'h0C;
  localparam logic [4:0] ROP_DCR_BLEND_MODE    = 5'h0D;
  localparam logic [4:0] ROP_DCR_BLEND_FUNC    = 5'h0E;
  localparam logic [4:0] ROP_DCR_BLEND_CONST   = 5'h0F;
  localparam logic [4:0] ROP_DCR_LOGIC_OP      = 5'h10;
  localparam logic [4:0] ROP_DCR_COMMIT        = 5'h11;
  localparam int         ROP_DCR_COUNT         = 18;

  function automatic rop_dcrs_t rop_dcrs_reset();
    rop_dcrs_t r;
    r = '0;
    r.cbuf_mask          = 32'hFFFF_FFFF;
    r.stencil_front_mask = 8'hFF;
    r.stencil_back_mask  = 8'hFF;
    return r;
  endfunction

  localparam rop_dcrs_t ROP_DCRS_RESET = rop_dcrs_reset();

  // Inverse of the write decode: register image of one index, unused bits 0.
  function automatic logic [31:0] rop_dcr_pack(
    input rop_dcrs_t  d,
    input logic [4:0] idx
  );
    logic [31:0] w;
    w = '0;
    case (idx)
      ROP_DCR_CBUF_ADDR:  w = d.cbuf_addr;
      ROP_DCR_CBUF_PITCH: w = d.cbuf_pitch;
      ROP_DCR_CBUF_MASK:  w = d.cbuf_mask;
      ROP_DCR_ZBUF_ADDR:  w = d.zbuf_addr;
      ROP_DCR_ZBUF_PITCH: w = d.zbuf_pitch;
      ROP_DCR_DEPTH_FUNC: w[0+:ROP_FUNC_BITS] = d.depth_func;
      ROP_DCR_DEPTH_MASK: w[0] = d.depth_writemask;
      ROP_DCR_STENCIL_FUNC: begin
        w[0+:ROP_FUNC_BITS]  = d.stencil_front_func;
        w[16+:ROP_FUNC_BITS] = d.stencil_back_func;
      end
      ROP_DCR_STENCIL_ZPASS: begin
        w[0+:ROP_OP_BITS]  = d.stencil_front_zpass;
        w[16+:ROP_OP_BITS] = d.stencil_back_zpass;
      end
      ROP_DCR_STENCIL_ZFAIL: begin
        w[0+:ROP_OP_BITS]  = d.stencil_front_zfail;
        w[16+:ROP_OP_BITS] = d.stencil_back_zfail;
      end
      ROP_DCR_STENCIL_FAIL: begin
        w[0+:ROP_OP_BITS]  = d.stencil_front_fail;
        w[16+:ROP_OP_BITS] = d.stencil_back_fail;
      end
      ROP_DCR_STENCIL_REF: begin
        w[7:0]   = d.stencil_front_ref;
        w[23:16] = d.stencil_back_ref;
      end
      ROP_DCR_STENCIL_MASK: begin
        w[7:0]   = d.stencil_front_mask;
        w[23:16] = d.stencil_back_mask;
      end
      ROP_DCR_BLEND_MODE: begin
        w[0+:ROP_MODE_BITS]  = d.blend_mode_rgb;
        w[16+:ROP_MODE_BITS] = d.blend_mode_a;
      end
      ROP_DCR_BLEND_FUNC: begin
        w[0+:ROP_BLEND_BITS]  = d.blend_src_rgb;
        w[8+:ROP_BLEND_BITS]  = d.blend_src_a;
        w[16+:ROP_BLEND_BITS] = d.blend_dst_rgb;
        w[24+:ROP_BLEND_BITS] = d.blend_dst_a;
      end
      ROP_DCR_BLEND_CONST: w = d.blend_const;
      ROP_DCR_LOGIC_OP:    w[0+:ROP_LOGIC_BITS] = d.logic_op;
      default:             w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rop_dcr_decode.sv
// Applies one DCR write (index, data) to a ROP state copy.
// Indices outside the register map (including COMMIT) leave the copy unchanged.
module rop_dcr_decode
  import rop_types::*;
(
  input  rop_dcrs_t   cur,
  input  logic [4:0]  idx,
  input  logic [31:0] data,
  output rop_dcrs_t   next
);

  localparam int F = ROP_FUNC_BITS;
  localparam int S = ROP_OP_BITS;
  localparam int M = ROP_MODE_BITS;
  localparam int B = ROP_BLEND_BITS;
  localparam int L = ROP_LOGIC_BITS;

  always_comb begin
    next = cur;
    case (idx)
      ROP_DCR_CBUF_ADDR:  next.cbuf_addr  = data;
      ROP_DCR_CBUF_PITCH: next.cbuf_pitch = data;
      ROP_DCR_CBUF_MASK:  next.cbuf_mask  = data;
      ROP_DCR_ZBUF_ADDR:  next.zbuf_addr  = data;
      ROP_DCR_ZBUF_PITCH: next.zbuf_pitch = data;
      ROP_DCR_DEPTH_FUNC: next.depth_func = data[0+:F];
      ROP_DCR_DEPTH_MASK: next.depth_writemask = data[0];
      ROP_DCR_STENCIL_FUNC: begin
        next.stencil_front_func = data[0+:F];
        next.stencil_back_func  = data[16+:F];
      end
      ROP_DCR_STENCIL_ZPASS: begin
        next.stencil_front_zpass = data[0+:S];
        next.stencil_back_zpass  = data[16+:S];
      end
      ROP_DCR_STENCIL_ZFAIL: begin
        next.stencil_front_zfail = data[0+:S];
        next.stencil_back_zfail  = data[16+:S];
      end
      ROP_DCR_STENCIL_FAIL: begin
        next.stencil_front_fail = data[0+:S];
        next.stencil_back_fail  = data[16+:S];
      end
      ROP_DCR_STENCIL_REF: begin
        next.stencil_front_ref = data[7:0];
        next.stencil_back_ref  = data[23:16];
      end
      ROP_DCR_STENCIL_MASK: begin
        next.stencil_front_mask = data[7:0];
        next.stencil_back_mask  = data[23:16];
      end
      ROP_DCR_BLEND_MODE: begin
        next.blend_mode_rgb = data[0+:M];
        next.blend_mode_a   = data[16+:M];
      end
      ROP_DCR_BLEND_FUNC: begin
        next.blend_src_rgb = data[0+:B];
        next.blend_src_a   = data[8+:B];
        next.blend_dst_rgb = data[16+:B];
        next.blend_dst_a   = data[24+:B];
      end
      ROP_DCR_BLEND_CONST: next.blend_const = data;
      ROP_DCR_LOGIC_OP:    next.logic_op    = data[0+:L];
      default: ;
    endcase
  end

endmodule

// File: rtl/rop_dcr_commit.sv
// ROP DCR staging/active copies with drain-then-commit FSM.
// Optional staging readback port when ROP_DCR_READBACK_EN is defined.
module rop_dcr_commit
  import rop_types::*;
#(
  parameter int                         DCR_ADDR_BITS = 12,
  parameter logic [DCR_ADDR_BITS-1:0]   DCR_BASE      = 'h100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dcr_wr_valid,
  output logic                     dcr_wr_ready,
  input  logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
  input  logic [31:0]              dcr_wr_data,
  input  logic                     rop_busy,
  output logic                     rop_stall,
  output logic                     commit_done,
`ifdef ROP_DCR_READBACK_EN
  input  logic                     dcr_rd_valid,
  input  logic [DCR_ADDR_BITS-1:0] dcr_rd_addr,
  output logic [31:0]              dcr_rd_data,
`endif
  output rop_dcrs_t                dcrs
);

  localparam logic [DCR_ADDR_BITS-1:0] COUNT =
    DCR_ADDR_BITS'(ROP_DCR_COUNT);
  localparam logic [DCR_ADDR_BITS-1:0] COMMIT =
    DCR_ADDR_BITS'(ROP_DCR_COMMIT);

  commit_state_t            state;
  rop_dcrs_t                staging;
  rop_dcrs_t                staging_next;
  logic [DCR_ADDR_BITS-1:0] wr_idx;
  logic                     wr_fire;
  logic                     wr_hit;
  logic                     commit_fire;

  // Addresses below the base wrap to large indices and fall out of range.
  assign wr_idx      = dcr_wr_addr - DCR_BASE;
  assign wr_fire     = dcr_wr_valid & dcr_wr_ready;
  assign wr_hit      = wr_fire & (wr_idx < COUNT);
  assign commit_fire = wr_fire & (wr_idx == COMMIT);

  rop_dcr_decode u_decode (
    .cur  (staging),
    .idx  (wr_idx[4:0]),
    .data (dcr_wr_data),
    .next (staging_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      rop_stall    <= 1'b0;
      dcr_wr_ready <= 1'b1;
      commit_done  <= 1'b0;
      staging      <= ROP_DCRS_RESET;
      dcrs         <= ROP_DCRS_RESET;
    end else begin
      commit_done <= 1'b0;
      if (wr_hit) begin
        staging <= staging_next;
      end
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (commit_fire) begin
            state        <= ST_DRAIN;
            rop_stall    <= 1'b1;
            dcr_wr_ready <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // Writes are back-pressured here, so staging is stable.
          if (!rop_busy) begin
            dcrs         <= staging;
            state        <= ST_DONE;
            rop_stall    <= 1'b0;
            dcr_wr_ready <= 1'b1;
            commit_done  <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          rop_stall    <= 1'b0;
          dcr_wr_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ROP_DCR_READBACK_EN
  logic [DCR_ADDR_BITS-1:0] rd_idx;

  assign rd_idx = dcr_rd_addr - DCR_BASE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcr_rd_data <= '0;
    end else if (dcr_rd_valid) begin
      dcr_rd_data <= (rd_idx < COUNT) ?
        rop_dcr_pack(staging, rd_idx[4:0]) : 32'h0;
    end
  end
`endif

endmodule

// File: tb/tb_rop_dcr_commit.sv
// Bench for rop_dcr_commit: word-level register model plus directed vectors.
// Build with ROP_DCR_READBACK_EN to also cover the readback port.
module tb_rop_dcr_commit;
  import rop_types::*;

  localparam int NW = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dcr_wr_valid = 1'b0;
  logic        dcr_wr_ready;
  logic [11:0] dcr_wr_addr = '0;
  logic [31:0] dcr_wr_data = '0;
  logic        rop_busy = 1'b0;
  logic        rop_stall;
  logic        commit_done;
  rop_dcrs_t   dcrs;
`ifdef ROP_DCR_READBACK_EN
  logic        dcr_rd_valid = 1'b0;
  logic [11:0] dcr_rd_addr = '0;
  logic [31:0] dcr_rd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rop_dcr_commit dut (
    .clk          (clk),
    .reset        (reset),
    .dcr_wr_valid (dcr_wr_valid),
    .dcr_wr_ready (dcr_wr_ready),
    .dcr_wr_addr  (dcr_wr_addr),
    .dcr_wr_data  (dcr_wr_data),
    .rop_busy     (rop_busy),
    .rop_stall    (rop_stall),
    .commit_done  (commit_done),
`ifdef ROP_DCR_READBACK_EN
    .dcr_rd_valid (dcr_rd_valid),
    .dcr_rd_addr  (dcr_rd_addr),
    .dcr_rd_data  (dcr_rd_data),
`endif
    .dcrs         (dcrs)
  );

  // Meaningful bits of each register index.
  function automatic logic [31:0] wmask(int i);
    case (i)
      5:                 return 32'h0000_0007;
      6:                 return 32'h0000_0001;
      7, 8, 9, 10, 13:   return 32'h0007_0007;
      11, 12:            return 32'h00FF_00FF;
      14:                return 32'h0F0F_0F0F;
      16:                return 32'h0000_000F;
      default:           return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] rst_word(int i);
    case (i)
      2:       return 32'hFFFF_FFFF;
      12:      return 32'h00FF_00FF;
      default: return 32'h0;
    endcase
  endfunction

  // DUT struct viewed as register words.
  function automatic logic [31:0] to_word(rop_dcrs_t d, int i);
    logic [31:0] w;
    w = '0;
    case (i)
      0:  w = d.cbuf_addr;
      1:  w = d.cbuf_pitch;
      2:  w = d.cbuf_mask;
      3:  w = d.zbuf_addr;
      4:  w = d.zbuf_pitch;
      5:  w[2:0] = d.depth_func;
      6:  w[0] = d.depth_writemask;
      7:  begin w[2:0] = d.stencil_front_func;  w[18:16] = d.stencil_back_func;  end
      8:  begin w[2:0] = d.stencil_front_zpass; w[18:16] = d.stencil_back_zpass; end
      9:  begin w[2:0] = d.stencil_front_zfail; w[18:16] = d.stencil_back_zfail; end
      10: begin w[2:0] = d.stencil_front_fail;  w[18:16] = d.stencil_back_fail;  end
      11: begin w[7:0] = d.stencil_front_ref;   w[23:16] = d.stencil_back_ref;   end
      12: begin w[7:0] = d.stencil_front_mask;  w[23:16] = d.stencil_back_mask;  end
      13: begin w[2:0] = d.blend_mode_rgb;      w[18:16] = d.blend_mode_a;       end
      14: begin
        w[3:0]   = d.blend_src_rgb;
        w[11:8]  = d.blend_src_a;
        w[19:16] = d.blend_dst_rgb;
        w[27:24] = d.blend_dst_a;
      end
      15: w = d.blend_const;
      16: w[3:0] = d.logic_op;
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for the pipe to empty, 2 commit just landed.
  logic [31:0] m_stage [NW];
  logic [31:0] m_act   [NW];
  int          m_phase;
  logic [31:0] m_rd;
  int          wi;
  bit          acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) begin
        m_stage[i] <= rst_word(i);
        m_act[i]   <= rst_word(i);
      end
      m_phase <= 0;
      m_rd    <= '0;
    end else begin
      wi  = int'(dcr_wr_addr) - 'h100;
      acc = dcr_wr_valid && (m_phase != 1);
`ifdef ROP_DCR_READBACK_EN
      if (dcr_rd_valid) begin
        if (int'(dcr_rd_addr) >= 'h100 && int'(dcr_rd_addr) < 'h100 + NW)
          m_rd <= m_stage[int'(dcr_rd_addr) - 'h100];
        else
          m_rd <= '0;
      end
`endif
      if (m_phase == 1) begin
        if (!rop_busy) begin
          for (int i = 0; i < NW; i++) m_act[i] <= m_stage[i];
          m_phase <= 2;
        end
      end else begin
        m_phase <= (acc && wi == 17) ? 1 : 0;
        if (acc && wi >= 0 && wi < NW)
          m_stage[wi] <= dcr_wr_data & wmask(wi);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("stall", 32'(rop_stall), 32'(m_phase == 1));
      chk("ready", 32'(dcr_wr_ready), 32'(m_phase != 1));
      chk("commit_done", 32'(commit_done), 32'(m_phase == 2));
      for (int i = 0; i < NW; i++)
        chk($sformatf("dcrs[%0d]", i), to_word(dcrs, i), m_act[i]);
`ifdef ROP_DCR_READBACK_EN
      chk("rd_data", dcr_rd_data, m_rd);
`endif
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called at posedge+2; returns at accept edge + 2.
  task automatic wr(logic [11:0] a, logic [31:0] d);
    logic r;
    bit   ok;
    ok = 1'b0;
    dcr_wr_valid = 1'b1;
    dcr_wr_addr  = a;
    dcr_wr_data  = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      r = dcr_wr_ready;
      @(posedge clk);
      ok = r;
    end
    if (!ok) chk("wr_timeout", 32'h0, 32'h1);
    #2;
    dcr_wr_valid = 1'b0;
  endtask

  int pulses;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_cbuf_mask", dcrs.cbuf_mask, 32'hFFFF_FFFF);
    chk("rst_sfmask", 32'(dcrs.stencil_front_mask), 32'hFF);
    chk("rst_sbmask", 32'(dcrs.stencil_back_mask), 32'hFF);
    chk("rst_cbuf_addr", dcrs.cbuf_addr, 32'h0);
    chk("rst_stall", 32'(rop_stall), 32'h0);
    chk("rst_done", 32'(commit_done), 32'h0);

    // Staged write is invisible until COMMIT lands one edge after accept
    wr(12'h100, 32'h8000_0000);
    tick(2);
    chk("t2_staged", dcrs.cbuf_addr, 32'h0);
    wr(12'h111, 32'h0);
    chk("t2_drain_stall", 32'(rop_stall), 32'h1);
    chk("t2_pre", dcrs.cbuf_addr, 32'h0);
    tick(1);
    chk("t2_post", dcrs.cbuf_addr, 32'h8000_0000);
    chk("t2_pulse", 32'(commit_done), 32'h1);
    tick(1);
    chk("t2_pulse_end", 32'(commit_done), 32'h0);

    // Busy pipe holds the commit off
    wr(12'h10B, 32'h00AB_00CD);
    rop_busy = 1'b1;
    wr(12'h111, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall", 32'(rop_stall), 32'h1);
      chk("t3_ready", 32'(dcr_wr_ready), 32'h0);
      chk("t3_held", 32'(dcrs.stencil_front_ref), 32'h0);
      tick(1);
    end
    rop_busy = 1'b0;
    tick(2);
    chk("t3_fref", 32'(dcrs.stencil_front_ref), 32'hCD);
    chk("t3_bref", 32'(dcrs.stencil_back_ref), 32'hAB);

    // Out-of-range writes are accepted and dropped
    wr(12'h112, 32'hDEAD_BEEF);
    wr(12'h0FF, 32'h1234_5678);
    wr(12'h111, 32'h0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (commit_done) pulses++;
    end
    chk("t4_pulses", 32'(pulses), 32'h1);
    chk("t4_cbuf", dcrs.cbuf_addr, 32'h8000_0000);
    chk("t4_mask", dcrs.cbuf_mask, 32'hFFFF_FFFF);

    // Unused data bits and back-to-back commits
    wr(12'h105, 32'hFFFF_FFFE);
    wr(12'h10E, 32'hFFFF_FFFF);
    wr(12'h110, 32'h0000_00AB);
    wr(12'h10A, 32'h0005_0002);
    wr(12'h111, 32'h0);
    wr(12'h111, 32'h0);
    tick(3);
    chk("t5_dfunc", 32'(dcrs.depth_func), 32'h6);
    chk("t5_lop", 32'(dcrs.logic_op), 32'hB);
    chk("t5_srca", 32'(dcrs.blend_src_a), 32'hF);
    chk("t5_bfail", 32'(dcrs.stencil_back_fail), 32'h5);

    // Reset while draining discards everything
    wr(12'h10F, 32'h1122_3344);
    rop_busy = 1'b1;
    wr(12'h111, 32'h0);
    tick(2);
    reset = 1'b1;
    #1;
    chk("t6_stall", 32'(rop_stall), 32'h0);
    chk("t6_ready", 32'(dcr_wr_ready), 32'h1);
    chk("t6_bconst", dcrs.blend_const, 32'h0);
    chk("t6_cbuf", dcrs.cbuf_addr, 32'h0);
    tick(1);
    reset = 1'b0;
    rop_busy = 1'b0;
    tick(2);
    wr(12'h111, 32'h0);
    tick(2);
    chk("t6_bconst_post", dcrs.blend_const, 32'h0);

`ifdef ROP_DCR_READBACK_EN
    wr(12'h10E, 32'h0302_0100);
    dcr_rd_valid = 1'b1;
    dcr_rd_addr  = 12'h10E;
    tick(1);
    chk("rd_bfunc", dcr_rd_data, 32'h0302_0100);
    dcr_rd_addr = 12'h111;
    tick(1);
    chk("rd_commit", dcr_rd_data, 32'h0);
    dcr_rd_addr = 12'h102;
    tick(1);
    chk("rd_cmask", dcr_rd_data, 32'hFFFF_FFFF);
    dcr_rd_valid = 1'b0;
    dcr_rd_addr  = 12'h10E;
    tick(2);
    chk("rd_hold", dcr_rd_data, 32'hFFFF_FFFF);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
